// File: rtl/bgpu_board_pkg.sv
// Shared types and constants for the BGPU board reset sequencer.
// The FSM encoding is exposed both as an enum and as plain 3-bit constants.
package bgpu_board_pkg;

    typedef enum logic [2:0] {
        RESET = 3'd0,
        CALIB = 3'd1,
        HOLD  = 3'd2,
        RUN   = 3'd3,
        ERROR = 3'd4
    } rst_state_e;

    localparam logic [2:0] ST_RESET = RESET;
    localparam logic [2:0] ST_CALIB = CALIB;
    localparam logic [2:0] ST_HOLD  = HOLD;
    localparam logic [2:0] ST_RUN   = RUN;
    localparam logic [2:0] ST_ERROR = ERROR;

    localparam int LED_READY   = 0;
    localparam int LED_RUN     = 1;
    localparam int LED_BTN     = 2;
    localparam int LED_TIMEOUT = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bgpu_debounce.sv
// Two-flop synchroniser followed by a level debouncer. The output level only
// changes after the synchronised input has differed from it for Cycles clocks.
module bgpu_debounce #(
    parameter int   Cycles   = 1000000,
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    localparam int CntW = $clog2((Cycles > 1) ? Cycles : 2);
    localparam logic [CntW-1:0] CntLast = CntW'(Cycles - 1);

    logic [1:0]      sync_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= {2{ResetVal}};
            stable_q <= ResetVal;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], d_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q_o = stable_q;

endmodule

// File: rtl/bgpu_board_rst_seq.sv
// Board bring-up sequencer: holds the SoC in reset until every memory channel
// is calibrated, adds a post-calibration hold, flags calibration timeouts.
module bgpu_board_rst_seq
    import bgpu_board_pkg::*;
#(
    parameter int   NumMctrl           = 1,
    parameter int   DebounceCycles     = 1000000,
    parameter int   RstHoldCycles      = 256,
    parameter int   CalibTimeoutCycles = 2**28,
    parameter int   NumLeds            = 8,
    parameter logic LedActiveLow       = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                btn_rst_ni,
    input  logic [NumMctrl-1:0] mctrl_rst_i,
    input  logic [NumMctrl-1:0] mctrl_calib_done_i,
    output logic                soc_rst_no,
    output logic [2:0]          state_o,
    output logic                calib_timeout_o,
    output logic [NumLeds-1:0]  led_o
);

    localparam int CntW = $clog2(max3(RstHoldCycles, CalibTimeoutCycles, 2) + 1);
    localparam logic [CntW-1:0] HoldLast    = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] TimeoutLast =
        CntW'((CalibTimeoutCycles > 0) ? CalibTimeoutCycles - 1 : 0);

    logic               btn_stable;
    logic               btn_pressed;
    logic               ready;
    logic [2:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic               timeout_q, timeout_d;
    logic               soc_rst_q;
    logic [NumLeds-1:0] led_q, led_lit;

    bgpu_debounce #(
        .Cycles   (DebounceCycles),
        .ResetVal (1'b1)
    ) u_btn_debounce (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (btn_rst_ni),
        .q_o   (btn_stable)
    );

    assign btn_pressed = ~btn_stable;
    assign ready       = &(mctrl_calib_done_i & ~mctrl_rst_i);
    assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RESET: begin
                if (!btn_pressed) begin
                    state_d = ST_CALIB;
                    cnt_d   = '0;
                end
            end
            ST_CALIB: begin
                if (ready) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (CalibTimeoutCycles != 0 && cnt_q == TimeoutLast) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!ready) begin
                    state_d = ST_CALIB;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RUN: begin
                if (!ready) begin
                    state_d = ST_CALIB;
                    cnt_d   = '0;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
        // A debounced press wins over every other transition, including a timeout.
        if (btn_pressed) begin
            state_d   = ST_RESET;
            cnt_d     = '0;
            timeout_d = timeout_q;
        end
    end

    always_comb begin
        led_lit              = '0;
        led_lit[LED_READY]   = ready;
        led_lit[LED_RUN]     = (state_d == ST_RUN);
        led_lit[LED_BTN]     = btn_pressed;
        led_lit[LED_TIMEOUT] = timeout_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            soc_rst_q <= 1'b0;
            led_q     <= {NumLeds{LedActiveLow}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            soc_rst_q <= (state_d == ST_RUN);
            led_q     <= led_lit ^ {NumLeds{LedActiveLow}};
        end
    end

    assign soc_rst_no      = soc_rst_q;
    assign state_o         = state_q;
    assign calib_timeout_o = timeout_q;
    assign led_o           = led_q;

endmodule

// File: tb/tb_bgpu_board_rst_seq.sv
// Scoreboard bench for bgpu_board_rst_seq: expectations are queued with the
// clock cycle they become due and compared on the falling edge of that cycle.
module tb_bgpu_board_rst_seq;
    import bgpu_board_pkg::*;

    localparam int NM = 2;
    localparam int NL = 8;
    localparam int S_STATE = 0;
    localparam int S_SOC   = 1;
    localparam int S_TO    = 2;
    localparam int S_LED   = 3;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          btn;
    logic [NM-1:0] mrst;
    logic [NM-1:0] mcal;
    logic          soc_rst_n;
    logic [2:0]    state;
    logic          tout;
    logic [NL-1:0] led;

    typedef struct {
        int          due;
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   t;

    bgpu_board_rst_seq #(
        .NumMctrl           (NM),
        .DebounceCycles     (8),
        .RstHoldCycles      (4),
        .CalibTimeoutCycles (16),
        .NumLeds            (NL),
        .LedActiveLow       (1'b1)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .btn_rst_ni         (btn),
        .mctrl_rst_i        (mrst),
        .mctrl_calib_done_i (mcal),
        .soc_rst_no         (soc_rst_n),
        .state_o            (state),
        .calib_timeout_o    (tout),
        .led_o              (led)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_STATE: return 32'(state);
            S_SOC:   return 32'(soc_rst_n);
            S_TO:    return 32'(tout);
            default: return 32'(led);
        endcase
    endfunction

    task automatic expect_at(input int due, input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due < cyc) check({e.tag, "_late"}, 32'(cyc), 32'(e.due));
            else             check(e.tag, observe(e.sig), e.val);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) tick(1);
        check("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        btn   = 1'b1;
        mrst  = '0;
        mcal  = '0;
        tick(3);
        check("init_state", 32'(state), 32'(RESET));
        check("init_soc",   32'(soc_rst_n), 32'd0);
        check("init_to",    32'(tout), 32'd0);
        check("init_led",   32'(led), 32'hFF);

        // Bring-up: one channel calibrated, then both.
        rst_i = 1'b0;
        t = cyc;
        expect_at(t + 1, "rel_calib", S_STATE, 32'(CALIB));
        tick(3);
        mcal = 2'b01;
        tick(2);
        t = cyc;
        mcal = 2'b11;
        expect_at(t,     "part_state",  S_STATE, 32'(CALIB));
        expect_at(t,     "part_led",    S_LED,   32'hFF);
        expect_at(t + 1, "bu_hold",     S_STATE, 32'(HOLD));
        expect_at(t + 1, "bu_led0",     S_LED,   32'hFE);
        expect_at(t + 4, "bu_hold_end", S_STATE, 32'(HOLD));
        expect_at(t + 4, "bu_soc_lo",   S_SOC,   32'd0);
        expect_at(t + 5, "bu_run",      S_STATE, 32'(RUN));
        expect_at(t + 5, "bu_soc_hi",   S_SOC,   32'd1);
        expect_at(t + 5, "bu_led_run",  S_LED,   32'hFC);
        drain();

        // Channel 1 re-reset for one cycle while running.
        tick(2);
        t = cyc;
        mrst = 2'b10;
        expect_at(t + 1, "loss_calib",   S_STATE, 32'(CALIB));
        expect_at(t + 1, "loss_soc_lo",  S_SOC,   32'd0);
        expect_at(t + 2, "loss_hold",    S_STATE, 32'(HOLD));
        expect_at(t + 5, "loss_hold_end",S_STATE, 32'(HOLD));
        expect_at(t + 5, "loss_soc_lo2", S_SOC,   32'd0);
        expect_at(t + 6, "loss_run",     S_STATE, 32'(RUN));
        expect_at(t + 6, "loss_soc_hi",  S_SOC,   32'd1);
        tick(1);
        mrst = 2'b00;
        drain();

        // Short button glitch is ignored.
        t = cyc;
        btn = 1'b0;
        expect_at(t + 7,  "glitch_run",  S_STATE, 32'(RUN));
        expect_at(t + 12, "glitch_run2", S_STATE, 32'(RUN));
        expect_at(t + 12, "glitch_soc",  S_SOC,   32'd1);
        tick(5);
        btn = 1'b1;
        drain();

        // Long press: reset 10 cycles after the first sampling edge, then release.
        t = cyc;
        btn = 1'b0;
        expect_at(t + 10, "press_pre",    S_STATE, 32'(RUN));
        expect_at(t + 10, "press_pre_soc",S_SOC,   32'd1);
        expect_at(t + 11, "press_reset",  S_STATE, 32'(RESET));
        expect_at(t + 11, "press_soc_lo", S_SOC,   32'd0);
        expect_at(t + 15, "press_led",    S_LED,   32'hFA);
        expect_at(t + 30, "rel_pre",      S_STATE, 32'(RESET));
        expect_at(t + 31, "rel_calib2",   S_STATE, 32'(CALIB));
        expect_at(t + 32, "rel_hold",     S_STATE, 32'(HOLD));
        expect_at(t + 36, "rel_run",      S_STATE, 32'(RUN));
        expect_at(t + 36, "rel_soc_hi",   S_SOC,   32'd1);
        tick(20);
        btn = 1'b1;
        drain();

        // Debounced press lands on the same edge as the calibration timeout.
        t = cyc;
        mcal = 2'b00;
        expect_at(t + 1,  "sim_calib",  S_STATE, 32'(CALIB));
        expect_at(t + 16, "sim_pre",    S_STATE, 32'(CALIB));
        expect_at(t + 17, "sim_reset",  S_STATE, 32'(RESET));
        expect_at(t + 17, "sim_to_lo",  S_TO,    32'd0);
        expect_at(t + 20, "sim_reset2", S_STATE, 32'(RESET));
        tick(6);
        btn = 1'b0;
        tick(14);
        btn = 1'b1;
        expect_at(t + 31, "to_calib",   S_STATE, 32'(CALIB));
        expect_at(t + 46, "to_pre",     S_STATE, 32'(CALIB));
        expect_at(t + 46, "to_pre_flag",S_TO,    32'd0);
        expect_at(t + 47, "to_error",   S_STATE, 32'(ERROR));
        expect_at(t + 47, "to_flag",    S_TO,    32'd1);
        expect_at(t + 47, "to_led",     S_LED,   32'hF7);
        drain();

        // Calibration completing late does not leave ERROR.
        tick(2);
        mcal = 2'b11;
        t = cyc;
        expect_at(t + 3, "err_stay",     S_STATE, 32'(ERROR));
        expect_at(t + 3, "err_stay_led", S_LED,   32'hF6);
        drain();

        // Button press leaves ERROR; sticky flag survives the full bring-up.
        t = cyc;
        btn = 1'b0;
        expect_at(t + 10, "err_pre",     S_STATE, 32'(ERROR));
        expect_at(t + 11, "err_reset",   S_STATE, 32'(RESET));
        expect_at(t + 11, "err_flag",    S_TO,    32'd1);
        tick(15);
        btn = 1'b1;
        expect_at(t + 26, "err_calib",   S_STATE, 32'(CALIB));
        expect_at(t + 27, "err_hold",    S_STATE, 32'(HOLD));
        expect_at(t + 31, "err_run",     S_STATE, 32'(RUN));
        expect_at(t + 31, "err_soc_hi",  S_SOC,   32'd1);
        expect_at(t + 31, "err_flag2",   S_TO,    32'd1);
        expect_at(t + 31, "err_led",     S_LED,   32'hF4);
        drain();

        // Asynchronous reset mid-RUN takes effect before the next clock edge.
        tick(3);
        rst_i = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'(RESET));
        check("arst_soc",   32'(soc_rst_n), 32'd0);
        check("arst_to",    32'(tout), 32'd0);
        check("arst_led",   32'(led), 32'hFF);
        tick(2);
        rst_i = 1'b0;
        t = cyc;
        expect_at(t + 1, "arst_calib", S_STATE, 32'(CALIB));
        expect_at(t + 2, "arst_hold",  S_STATE, 32'(HOLD));
        expect_at(t + 6, "arst_run",   S_STATE, 32'(RUN));
        expect_at(t + 6, "arst_soc",   S_SOC,   32'd1);
        expect_at(t + 6, "arst_to2",   S_TO,    32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
